// File: rtl/normlize_pkg.sv
// Shared types and widths for the 2x2 weight-normalization sequencer.
package normlize_pkg;

  localparam int W_IN  = 16;
  localparam int W_RES = 32;
  localparam int W_CNT = 8;

  typedef enum logic [2:0] {
    IDLE,
    RUN_C1,
    FLUSH,
    RUN_C2,
    DONE
  } state_e;

endpackage

// File: rtl/normlize_lat_cnt.sv
// Up-counter with synchronous clear and a terminal-count flag at limit_i.
module normlize_lat_cnt
  import normlize_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [W_CNT-1:0] limit_i,
  output logic             tc_o
);

  logic [W_CNT-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign tc_o = en_i && (cnt_q == limit_i);

endmodule

// File: rtl/normlize_w_ctrl.sv
// Time-shares one normalize datapath across both weight columns and
// collects the four normalized results behind a single done pulse.
module normlize_w_ctrl
  import normlize_pkg::*;
#(
  parameter int P_DP_LATENCY = 40,
  parameter int P_FLUSH      = 2
) (
  input  logic             I_sys_clk,
  input  logic             I_sys_rst,
  input  logic             I_start,
  input  logic [W_IN-1:0]  I_w_1_1,
  input  logic [W_IN-1:0]  I_w_2_1,
  input  logic [W_IN-1:0]  I_w_1_2,
  input  logic [W_IN-1:0]  I_w_2_2,
  output logic             O_dp_ena,
  output logic [W_IN-1:0]  O_dp_a,
  output logic [W_IN-1:0]  O_dp_b,
  input  logic [W_RES-1:0] I_dp_res_a,
  input  logic [W_RES-1:0] I_dp_res_b,
  output logic [W_RES-1:0] O_w_1_1_normalize,
  output logic [W_RES-1:0] O_w_2_1_normalize,
  output logic [W_RES-1:0] O_w_1_2_normalize,
  output logic [W_RES-1:0] O_w_2_2_normalize,
  output logic             O_busy,
  output logic             O_done,
  output logic [1:0]       O_err_zero
);

  localparam logic [W_CNT-1:0] LIM_RUN   = W_CNT'(P_DP_LATENCY - 1);
  localparam logic [W_CNT-1:0] LIM_FLUSH = W_CNT'(P_FLUSH - 1);

  state_e state_q, state_d;

  logic [W_IN-1:0]  dp_a_q, dp_b_q, w12_q, w22_q;
  logic [W_RES-1:0] r11_q, r21_q, r12_q, r22_q;
  logic [1:0]       err_q;
  logic             tc, cnt_en, cnt_clr;
  logic [W_CNT-1:0] cnt_lim;
  logic             col1_zero, col2_zero, accept;

  assign col1_zero = (I_w_1_1 == '0) && (I_w_2_1 == '0);
  assign col2_zero = (w12_q == '0) && (w22_q == '0);
  assign accept    = (state_q == IDLE) && I_start;

  assign cnt_en  = (state_q == RUN_C1) || (state_q == FLUSH) || (state_q == RUN_C2);
  assign cnt_clr = tc || !cnt_en;
  assign cnt_lim = (state_q == FLUSH) ? LIM_FLUSH : LIM_RUN;

  normlize_lat_cnt u_lat_cnt (
    .clk_i   (I_sys_clk),
    .rst_i   (I_sys_rst),
    .clr_i   (cnt_clr),
    .en_i    (cnt_en),
    .limit_i (cnt_lim),
    .tc_o    (tc)
  );

  always_ff @(posedge I_sys_clk) begin
    if (I_sys_rst) state_q <= IDLE;
    else           state_q <= state_d;
  end

  // A zero column 2 needs no flush: nothing follows it on the datapath.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (I_start) state_d = col1_zero ? FLUSH : RUN_C1;
      RUN_C1:  if (tc) state_d = FLUSH;
      FLUSH: begin
        if (col2_zero) state_d = DONE;
        else if (tc)   state_d = RUN_C2;
      end
      RUN_C2:  if (tc) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    O_dp_ena = (state_q == RUN_C1) || (state_q == RUN_C2);
    O_done   = (state_q == DONE);
    O_busy   = (state_q != IDLE);
  end

  always_ff @(posedge I_sys_clk) begin
    if (I_sys_rst) begin
      dp_a_q <= '0;
      dp_b_q <= '0;
      w12_q  <= '0;
      w22_q  <= '0;
      r11_q  <= '0;
      r21_q  <= '0;
      r12_q  <= '0;
      r22_q  <= '0;
      err_q  <= '0;
    end else begin
      if (accept) begin
        dp_a_q <= I_w_1_1;
        dp_b_q <= I_w_2_1;
        w12_q  <= I_w_1_2;
        w22_q  <= I_w_2_2;
        r11_q  <= '0;
        r21_q  <= '0;
        r12_q  <= '0;
        r22_q  <= '0;
        err_q  <= {1'b0, col1_zero};
      end
      if ((state_q == RUN_C1) && tc) begin
        r11_q <= I_dp_res_a;
        r21_q <= I_dp_res_b;
      end
      if (state_q == FLUSH) begin
        if (col2_zero) begin
          err_q[1] <= 1'b1;
        end else if (tc) begin
          dp_a_q <= w12_q;
          dp_b_q <= w22_q;
        end
      end
      if ((state_q == RUN_C2) && tc) begin
        r12_q <= I_dp_res_a;
        r22_q <= I_dp_res_b;
      end
    end
  end

  assign O_dp_a            = dp_a_q;
  assign O_dp_b            = dp_b_q;
  assign O_w_1_1_normalize = r11_q;
  assign O_w_2_1_normalize = r21_q;
  assign O_w_1_2_normalize = r12_q;
  assign O_w_2_2_normalize = r22_q;
  assign O_err_zero        = err_q;

endmodule
